// File: rtl/serv_mtimer.sv
// RISC-V machine timer (mtime/mtimecmp) behind a Wishbone slave port.
// Runs on the free-running clock so mtime advances and can wake a halted core.
module serv_mtimer #(
  parameter int WIDTH          = 32,
  parameter int PRESCALE_BITS  = 0,
  parameter     RESET_STRATEGY = "MINI"
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_wb_cyc,
  input  logic        i_wb_we,
  input  logic [1:0]  i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic [3:0]  i_wb_sel,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_timer_irq
);

  localparam bit          RST_DATA = (RESET_STRATEGY != "NONE");
  localparam bit          HI_EN    = (WIDTH == 64);
  // Storage is always 64 bits wide; the mask pins the upper word to zero for WIDTH = 32.
  localparam logic [63:0] MASK     = HI_EN ? {64{1'b1}} : 64'h0000_0000_ffff_ffff;

  logic [63:0] mtime_q, mtime_d;
  logic [63:0] mtimecmp_q, mtimecmp_d;
  logic [31:0] rdt_q, rdt_d;
  logic        ack_q, ack_d;
  logic        irq_q, irq_d;
  logic        tick;
  logic        access, wr;
  logic        wr_time_lo, wr_time_hi, wr_cmp_lo, wr_cmp_hi;

  function automatic logic [31:0] byte_merge(input logic [31:0] old_v,
                                             input logic [31:0] new_v,
                                             input logic [3:0]  sel);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = sel[b] ? new_v[8*b +: 8] : old_v[8*b +: 8];
    end
    return res;
  endfunction

  generate
    if (PRESCALE_BITS == 0) begin : g_no_prescale
      assign tick = 1'b1;
    end else begin : g_prescale
      logic [PRESCALE_BITS-1:0] presc_q;
      always_ff @(posedge i_clk) begin
        if (i_rst && RST_DATA) presc_q <= '0;
        else                   presc_q <= presc_q + 1'b1;
      end
      assign tick = &presc_q;
    end
  endgenerate

  // One commit slot per transaction: the cycle before ack is raised.
  always_comb begin
    access     = i_wb_cyc & ~ack_q;
    wr         = access & i_wb_we;
    wr_time_lo = wr & (i_wb_adr == 2'd0);
    wr_time_hi = wr & (i_wb_adr == 2'd1) & HI_EN;
    wr_cmp_lo  = wr & (i_wb_adr == 2'd2);
    wr_cmp_hi  = wr & (i_wb_adr == 2'd3) & HI_EN;
  end

  // A bus write to mtime replaces that cycle's increment for the whole counter.
  always_comb begin
    mtime_d = mtime_q;
    if (wr_time_lo || wr_time_hi) begin
      if (wr_time_lo) mtime_d[31:0]  = byte_merge(mtime_q[31:0],  i_wb_dat, i_wb_sel);
      if (wr_time_hi) mtime_d[63:32] = byte_merge(mtime_q[63:32], i_wb_dat, i_wb_sel);
    end else if (tick) begin
      mtime_d = mtime_q + 64'd1;
    end
    mtime_d = mtime_d & MASK;

    mtimecmp_d = mtimecmp_q;
    if (wr_cmp_lo) mtimecmp_d[31:0]  = byte_merge(mtimecmp_q[31:0],  i_wb_dat, i_wb_sel);
    if (wr_cmp_hi) mtimecmp_d[63:32] = byte_merge(mtimecmp_q[63:32], i_wb_dat, i_wb_sel);
    mtimecmp_d = mtimecmp_d & MASK;
  end

  always_comb begin
    rdt_d = rdt_q;
    if (access) begin
      case (i_wb_adr)
        2'd0:    rdt_d = mtime_q[31:0];
        2'd1:    rdt_d = HI_EN ? mtime_q[63:32] : 32'd0;
        2'd2:    rdt_d = mtimecmp_q[31:0];
        default: rdt_d = HI_EN ? mtimecmp_q[63:32] : 32'd0;
      endcase
    end
    ack_d = i_wb_cyc & ~ack_q;
    irq_d = (mtime_q & MASK) >= (mtimecmp_q & MASK);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst && RST_DATA) begin
      mtime_q    <= '0;
      mtimecmp_q <= MASK;
    end else begin
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ack_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      ack_q <= ack_d;
      irq_q <= irq_d;
    end
  end

  always_ff @(posedge i_clk) begin
    rdt_q <= rdt_d;
  end

  assign o_wb_rdt    = rdt_q;
  assign o_wb_ack    = ack_q;
  assign o_timer_irq = irq_q;

endmodule

// File: doc/serv_mtimer.md
Name: serv_mtimer

Overview:
- Memory-mapped RISC-V machine timer (mtime/mtimecmp) on a Wishbone slave port.
- Drives the timer interrupt that the sleep controller uses as a wake source. It also feeds the core's timer interrupt input.
- Sits on the free-running (never gated) clock domain. mtime keeps advancing while the core clock is halted, and the interrupt can release the halt.

Parameters:
- WIDTH, 32, counter/compare width; legal values 32 or 64.
- PRESCALE_BITS, 0, mtime advances once every 2^PRESCALE_BITS i_clk cycles; 0 means every cycle.
- RESET_STRATEGY, "MINI", "NONE" leaves mtime, mtimecmp and the prescaler unreset. Any other value resets them.

Ports:
- i_clk  in  1  free-running clock
- i_rst  in  1  synchronous reset, active-high
- i_wb_cyc  in  1  bus request; held until o_wb_ack
- i_wb_we  in  1  1 = write
- i_wb_adr  in  2  word address [3:2]: 0 = mtime lo, 1 = mtime hi, 2 = mtimecmp lo, 3 = mtimecmp hi
- i_wb_dat  in  32  write data
- i_wb_sel  in  4  byte enables for writes
- o_wb_rdt  out  32  read data, valid when o_wb_ack = 1
- o_wb_ack  out  1  single-cycle acknowledge
- o_timer_irq  out  1  level interrupt, registered

Behaviour:
- Reset (i_rst high at a clock edge):
  - o_wb_ack = 0 and o_timer_irq = 0 always.
  - Unless RESET_STRATEGY = "NONE": mtime = 0, prescaler = 0, mtimecmp = all ones, so no interrupt fires after reset.
  - Reset asserted mid-transaction drops the pending ack; the master reissues the access.
- Prescaler:
  - Counter of PRESCALE_BITS bits, incremented every cycle, wraps.
  - tick = (prescaler == all ones); when PRESCALE_BITS = 0, tick = 1 every cycle.
  - Writes never touch the prescaler.
- mtime:
  - On tick, mtime <= mtime + 1, modulo 2^WIDTH (all ones wraps to 0, no flag).
  - A Wishbone write to an mtime word in the same cycle as a tick takes priority: the written bytes take the write data and the increment is discarded for the whole counter that cycle.
  - Unwritten bytes hold their value that cycle.
- Bus handshake:
  - o_wb_ack <= i_wb_cyc & !o_wb_ack. Ack therefore rises one cycle after cyc and lasts exactly one cycle.
  - Back-to-back accesses get one idle cycle between acks.
  - Writes are committed in the cycle where i_wb_cyc & i_wb_we & !o_wb_ack holds, i.e. exactly once per transaction, only to bytes with i_wb_sel set.
  - o_wb_rdt is registered in that same cycle and so reflects the value before any same-cycle write or increment.
  - o_wb_rdt is don't-care when o_wb_ack = 0.
- WIDTH = 32:
  - Addresses 1 and 3 read 0; writes to them are ignored.
  - No 64-bit read coherence is provided; software uses the hi-lo-hi read sequence.
- Interrupt:
  - o_timer_irq <= (mtime >= mtimecmp), unsigned compare over WIDTH bits, evaluated on the current register values.
  - Latency: one cycle after mtime reaches mtimecmp, or after the write that makes the compare true.
  - Stays high until software raises mtimecmp or mtime wraps; it is a level, never auto-cleared.
  - mtimecmp = 0 gives a permanently asserted interrupt.
- Clocking: the block never stalls and has no dependence on the core clock halt state.

Test Plan:
- Reset, then idle 10 cycles with PRESCALE_BITS = 0 -> read addr 0 returns 10 ± handshake offset; addr 2 reads 0xFFFFFFFF; o_timer_irq = 0 throughout.
- Write mtimecmp = 20 at t0 -> o_timer_irq rises exactly one cycle after mtime == 20; write mtimecmp = 100 -> irq falls one cycle after that write commits.
- Write mtime lo = 0x12345678 with sel = 0b0011 in a tick cycle -> mtime reads 0x????5678 with the upper half unchanged and no increment that cycle; the next cycle resumes +1.
- WIDTH = 32: preload mtime = 0xFFFFFFFE, mtimecmp = 0xFFFFFFFF -> irq asserts at all-ones, mtime wraps to 0, irq deasserts one cycle later; addr 1 reads 0.
- PRESCALE_BITS = 2 -> mtime increments once per 4 cycles; a write to mtime does not shift the tick phase.
- Hold i_wb_cyc with i_wb_we = 1 for 4 cycles -> exactly two acks, each one cycle wide; pulse i_rst while cyc is high -> no ack that cycle, o_timer_irq = 0, mtime = 0.
